// File: rtl/iobus_timer_if.sv
// IO bus target port bundle for the MCS timer slot.
// Master drives the access strobes; slave returns data and ready.
interface iobus_timer_if;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  modport master (
    output io_addr_strobe,
    output io_read_strobe,
    output io_write_strobe,
    output io_address,
    output io_byte_enable,
    output io_write_data,
    input  io_read_data,
    input  io_ready
  );

  modport slave (
    input  io_addr_strobe,
    input  io_read_strobe,
    input  io_write_strobe,
    input  io_address,
    input  io_byte_enable,
    input  io_write_data,
    output io_read_data,
    output io_ready
  );
endinterface

// File: rtl/iobus_timer.sv
// 32-bit down-counting timer on the MCS IO bus.
// Registered single-cycle-latency target with a level interrupt.
module iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFF0
) (
  input  logic          clk,
  input  logic          rst,
  iobus_timer_if.slave  bus,
  output logic          irq
);

  logic        en;
  logic        auto_rld;
  logic        irq_en;
  logic        expired;
  logic [31:0] load;
  logic [31:0] count;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic        sel;
  logic        wr;
  logic        rd;
  logic        fire;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rmux;
  logic        w_ctrl;
  logic        w_stat;
  logic        w_load;
  logic        w_count;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  lanes
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign sel  = (bus.io_address & ADDR_MASK) == BASE_ADDR;
  assign off  = bus.io_address[3:2];
  assign be   = bus.io_byte_enable;
  assign wd   = bus.io_write_data;
  // Both strobes together count as a write.
  assign wr   = bus.io_addr_strobe & sel & bus.io_write_strobe;
  assign rd   = bus.io_addr_strobe & sel & bus.io_read_strobe
              & ~bus.io_write_strobe;
  assign fire = en & (count == '0);

  always_comb begin
    w_ctrl  = 1'b0;
    w_stat  = 1'b0;
    w_load  = 1'b0;
    w_count = 1'b0;
    rmux    = '0;
    unique case (off)
      2'd0: begin
        w_ctrl = wr;
        rmux   = {29'd0, irq_en, auto_rld, en};
      end
      2'd1: begin
        w_stat = wr;
        rmux   = {31'd0, expired};
      end
      2'd2: begin
        w_load = wr;
        rmux   = load;
      end
      default: begin
        w_count = wr;
        rmux    = count;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq      <= 1'b0;
      en       <= 1'b0;
      auto_rld <= 1'b0;
      irq_en   <= 1'b0;
      expired  <= 1'b0;
      load     <= '0;
      count    <= '0;
    end else begin
      ready_q <= wr | rd;
      rdata_q <= rd ? rmux : '0;
      irq     <= expired & irq_en;

      if (en) begin
        if (!fire)
          count <= count - 32'd1;
        else if (auto_rld)
          count <= load;
        else
          en <= 1'b0;
      end

      // Expiry set beats a same-cycle write-1-clear.
      if (fire)
        expired <= 1'b1;
      else if (w_stat && be[0] && wd[0])
        expired <= 1'b0;

      // Bus writes come last so they beat counter updates.
      if (w_ctrl && be[0])
        {irq_en, auto_rld, en} <= wd[2:0];
      if (w_load)
        load <= merge(load, wd, be);
      if (w_count && (be != 4'b0000))
        count <= merge(count, wd, be);
    end
  end

  assign bus.io_ready     = ready_q;
  assign bus.io_read_data = rdata_q;

endmodule

// File: tb/tb_iobus_timer.sv
// Directed plus random bench for iobus_timer.
// Reference model tracks timer state by the register rules.
module tb_iobus_timer;
  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  always #5 clk = ~clk;

  iobus_timer_if bus();

  iobus_timer #(
    .BASE_ADDR(BASE),
    .ADDR_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  bit          m_en   = 0;
  bit          m_auto = 0;
  bit          m_ie   = 0;
  bit          m_exp  = 0;
  logic [31:0] m_load  = '0;
  logic [31:0] m_count = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] o);
    case (o)
      2'd0: return {29'd0, m_ie, m_auto, m_en};
      2'd1: return {31'd0, m_exp};
      2'd2: return m_load;
      default: return m_count;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // One bus cycle: drive, predict, clock, then check T+1 outputs.
  task automatic cyc(input bit as, input bit rs, input bit ws,
                     input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d);
    bit hit, w, r, fire, e_rdy, e_irq;
    bit ne, na, ni, nx;
    logic [31:0] er, nc, nl;
    bus.io_addr_strobe  = as;
    bus.io_read_strobe  = rs;
    bus.io_write_strobe = ws;
    bus.io_address      = a;
    bus.io_byte_enable  = b;
    bus.io_write_data   = d;
    hit   = (a & MASK) == BASE;
    w     = as && hit && ws;
    r     = as && hit && rs && !ws;
    e_rdy = !rst && (w || r);
    er    = (!rst && r) ? m_reg(a[3:2]) : 32'd0;
    e_irq = !rst && m_exp && m_ie;
    fire  = m_en && (m_count == 0);
    ne = m_en && !(fire && !m_auto);
    na = m_auto;
    ni = m_ie;
    if (!m_en)     nc = m_count;
    else if (!fire) nc = m_count - 1;
    else if (m_auto) nc = m_load;
    else           nc = 32'd0;
    nx = fire || (m_exp && !(w && a[3:2] == 2'd1 && b[0] && d[0]));
    nl = m_load;
    if (w) begin
      case (a[3:2])
        2'd0: if (b[0]) {ni, na, ne} = d[2:0];
        2'd2: nl = lanes(m_load, d, b);
        2'd3: if (b != 4'b0000) nc = lanes(m_count, d, b);
        default: ;
      endcase
    end
    @(posedge clk);
    if (rst) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
      m_load = '0; m_count = '0;
    end else begin
      m_en = ne; m_auto = na; m_ie = ni; m_exp = nx;
      m_load = nl; m_count = nc;
    end
    #1;
    chk("ready", {31'd0, bus.io_ready}, {31'd0, e_rdy});
    chk("rdata", bus.io_read_data, er);
    chk("irq", {31'd0, irq}, {31'd0, e_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, BASE, 4'h0, 32'd0);
  endtask

  task automatic rd_reg(input logic [1:0] o);
    cyc(1, 1, 0, BASE + {28'd0, o, 2'b00}, 4'h0, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] o, input logic [3:0] b,
                        input logic [31:0] d);
    cyc(1, 0, 1, BASE + {28'd0, o, 2'b00}, b, d);
  endtask

  initial begin
    bus.io_addr_strobe  = 0;
    bus.io_read_strobe  = 0;
    bus.io_write_strobe = 0;
    bus.io_address      = '0;
    bus.io_byte_enable  = '0;
    bus.io_write_data   = '0;
    rst = 1;
    idle(2);
    rst = 0;

    for (int o = 0; o < 4; o++) begin
      rd_reg(2'(o));
      chk("rst_ready", {31'd0, bus.io_ready}, 32'd1);
      chk("rst_data", bus.io_read_data, 32'd0);
    end

    wr_reg(2, 4'hF, 32'd5);
    wr_reg(3, 4'hF, 32'd5);
    wr_reg(0, 4'h1, 32'd7);
    idle(5);
    rd_reg(1);
    chk("exp_early", bus.io_read_data, 32'd0);
    rd_reg(1);
    chk("exp_set", bus.io_read_data, 32'd1);
    chk("irq_up", {31'd0, irq}, 32'd1);
    wr_reg(1, 4'h1, 32'd1);
    idle(3);
    rd_reg(1);
    chk("period_early", bus.io_read_data, 32'd0);
    rd_reg(1);
    chk("period_set", bus.io_read_data, 32'd1);
    wr_reg(0, 4'h1, 32'd0);
    wr_reg(1, 4'h1, 32'd1);

    wr_reg(3, 4'hF, 32'd2);
    wr_reg(0, 4'h1, 32'd1);
    idle(3);
    rd_reg(0);
    chk("oneshot_ctrl", bus.io_read_data, 32'd0);
    rd_reg(3);
    chk("oneshot_count", bus.io_read_data, 32'd0);
    rd_reg(1);
    chk("oneshot_exp", bus.io_read_data, 32'd1);
    wr_reg(1, 4'h1, 32'd1);
    rd_reg(1);
    chk("w1c", bus.io_read_data, 32'd0);

    wr_reg(2, 4'hF, 32'h1122_3344);
    wr_reg(2, 4'b0101, 32'hAABB_CCDD);
    rd_reg(2);
    chk("load_lanes", bus.io_read_data, 32'h11BB_33DD);
    wr_reg(2, 4'h0, 32'hFFFF_FFFF);
    chk("be0_ready", {31'd0, bus.io_ready}, 32'd1);
    rd_reg(2);
    chk("be0_keep", bus.io_read_data, 32'h11BB_33DD);

    cyc(1, 0, 1, BASE + 32'h1C, 4'hF, 32'h55);
    chk("oow_hi", {31'd0, bus.io_ready}, 32'd0);
    cyc(1, 1, 0, BASE - 32'd4, 4'h0, 32'd0);
    chk("oow_lo", {31'd0, bus.io_ready}, 32'd0);
    rd_reg(2);
    chk("b2b_8", bus.io_read_data, 32'h11BB_33DD);
    rd_reg(3);
    chk("b2b_c_rdy", {31'd0, bus.io_ready}, 32'd1);
    chk("b2b_c", bus.io_read_data, 32'd0);

    wr_reg(2, 4'hF, 32'd0);
    wr_reg(3, 4'hF, 32'd0);
    wr_reg(0, 4'h1, 32'd3);
    wr_reg(1, 4'h1, 32'd1);
    rd_reg(1);
    chk("clr_vs_set", bus.io_read_data, 32'd1);
    wr_reg(0, 4'h1, 32'd0);
    wr_reg(1, 4'h1, 32'd1);
    rd_reg(1);
    chk("clr_idle", bus.io_read_data, 32'd0);

    wr_reg(3, 4'hF, 32'd100);
    wr_reg(0, 4'h1, 32'd1);
    idle(2);
    wr_reg(3, 4'hF, 32'h40);
    rd_reg(3);
    chk("cnt_wr_wins", bus.io_read_data, 32'h40);
    wr_reg(0, 4'h1, 32'd0);

    wr_reg(2, 4'hF, 32'h1234);
    rd_reg(0);
    chk("pre_rst_rdy", {31'd0, bus.io_ready}, 32'd1);
    rst = 1;
    rd_reg(2);
    chk("rst_drop", {31'd0, bus.io_ready}, 32'd0);
    rst = 0;
    for (int o = 0; o < 4; o++) begin
      rd_reg(2'(o));
      chk("post_rst", bus.io_read_data, 32'd0);
    end

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d;
      logic [1:0] o;
      int k;
      o = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 99);
      if (k < 85) a = BASE + {28'd0, o, 2'($urandom_range(0, 3))};
      else if (k < 92) a = BASE + 32'h10 + {28'd0, o, 2'b00};
      else a = BASE - 32'd4;
      if (o >= 2 && $urandom_range(0, 3) != 0)
        d = 32'($urandom_range(0, 12));
      else
        d = $urandom;
      rst = ($urandom_range(0, 149) == 0);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          a, 4'($urandom), d);
    end
    rst = 0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
